// File: rtl/ap_writeback_pkg.sv
// ap_writeback_pkg
// Shared definitions for the arithmetic part: default lane geometry
// (bits per core result, number of cores) and the layer FSM state encoding
// used by the writeback collector and its neighbours.
package ap_writeback_pkg;

    localparam int OUTPORT = 8;  // bits per core result
    localparam int N_CORE  = 8;  // number of cores / lanes

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ap_state_e;

endpackage

// File: rtl/ap_wb_fifo.sv
// ap_wb_fifo
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever
// the FIFO is not empty, and pop consumes it.
// Ports:
//   clk, reset (sync, active-low)
//   push / din   : write an entry (accepted if not full, or if popping now)
//   pop  / dout  : consume the head entry (ignored when empty)
//   full, empty  : occupancy flags
module ap_wb_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ap_writeback.sv
// ap_writeback
// Collects per-core results from the core array, aligns the lanes of one
// output pixel into a packed word, buffers words in a FIFO and streams them
// to the output feature-map memory as addressed writes.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   start                 : layer start pulse (accepted in IDLE only)
//   base_addr, num_words  : first write address, words in this layer
//   lane_mask             : core i enabled by bit N_core-1-i
//   in, in_en             : core results (core 0 in MSBs) and strobes
//   wr_en, wr_addr,       : write request to output memory; a transfer
//   wr_data, wr_ready       happens when wr_en && wr_ready
//   busy, done, err       : status to the layer sequencer
//   o_state               : current FSM state (debug observation)
//
// Handshake: wr_en/wr_addr/wr_data are held stable until a cycle in which
// wr_ready is high; that cycle is the transfer and the next word (if any)
// is presented on the following cycle.
module ap_writeback
    import ap_writeback_pkg::*;
#(
    parameter int outport    = OUTPORT,
    parameter int N_core     = N_CORE,
    parameter int addr_w     = 16,
    parameter int cnt_w      = 16,
    parameter int fifo_depth = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_w-1:0]         base_addr,
    input  logic [cnt_w-1:0]          num_words,
    input  logic [N_core-1:0]         lane_mask,
    input  logic [outport*N_core-1:0] in,
    input  logic [N_core-1:0]         in_en,
    output logic                      wr_en,
    output logic [addr_w-1:0]         wr_addr,
    output logic [outport*N_core-1:0] wr_data,
    input  logic                      wr_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output ap_state_e                 o_state
);

    localparam int W = outport * N_core;
    localparam logic [cnt_w-1:0] CNT_ONE = 1;

    // Lanes are handled by bit position b (0 = LSB). Core i sits at
    // b = N_core-1-i in lane_mask/in_en and at in[b*outport +: outport],
    // so no index reversal is needed anywhere below.

    ap_state_e r_state;
    ap_state_e w_next_state;

    logic [addr_w-1:0]  r_base;
    logic [cnt_w-1:0]   r_num;
    logic [N_core-1:0]  r_mask;
    logic [N_core-1:0]  r_lane_valid;
    logic [outport-1:0] r_lane_data [N_core];
    logic [cnt_w-1:0]   r_push_cnt;   // completed words, pushed or dropped
    logic [cnt_w-1:0]   r_wr_cnt;     // words transferred to memory
    logic [cnt_w-1:0]   r_drop_cnt;   // words lost to a full FIFO
    logic               r_err;

    logic              w_start_acc;
    logic              w_capture_en;
    logic [N_core-1:0] w_strb;
    logic              w_complete;
    logic [W-1:0]      w_merged;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_dup;
    logic [cnt_w:0]    w_retired_nxt;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [W-1:0]      w_fifo_head;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    // Strobes only count while in RUN and before the layer's last word.
    assign w_capture_en = (r_state == ST_RUN) && (r_push_cnt != r_num);
    assign w_strb       = w_capture_en ? (in_en & r_mask) : '0;
    assign w_complete   = (|w_strb) &&
                          (((r_lane_valid | w_strb) & r_mask) == r_mask);
    assign w_dup        = |(w_strb & r_lane_valid);

    // Merged word: this cycle's strobe wins over the stored lane value;
    // masked-off lanes are forced to zero.
    always_comb begin
        w_merged = '0;
        for (int b = 0; b < N_core; b++) begin
            if (r_mask[b]) begin
                w_merged[b*outport +: outport] =
                    w_strb[b] ? in[b*outport +: outport] : r_lane_data[b];
            end
        end
    end

    assign w_pop  = wr_en && wr_ready;
    assign w_push = w_complete && (!w_fifo_full || w_pop);
    assign w_drop = w_complete && w_fifo_full && !w_pop;

    // Words retired after this edge; the layer ends when this reaches
    // num_words (every completed word is either written or dropped).
    assign w_retired_nxt = {1'b0, r_wr_cnt} + {1'b0, r_drop_cnt} +
                           {{cnt_w{1'b0}}, w_pop} + {{cnt_w{1'b0}}, w_drop};

    ap_wb_fifo #(
        .WIDTH (W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_merged),
        .pop   (w_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = (num_words == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_retired_nxt == {1'b0, r_num}) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Layer configuration, lane capture and counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_base       <= '0;
            r_num        <= '0;
            r_mask       <= '0;
            r_lane_valid <= '0;
            r_push_cnt   <= '0;
            r_wr_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_err        <= 1'b0;
            for (int b = 0; b < N_core; b++) r_lane_data[b] <= '0;
        end else if (w_start_acc) begin
            r_base       <= base_addr;
            r_num        <= num_words;
            r_mask       <= lane_mask;
            r_lane_valid <= '0;
            r_push_cnt   <= '0;
            r_wr_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            for (int b = 0; b < N_core; b++) begin
                if (w_strb[b]) r_lane_data[b] <= in[b*outport +: outport];
            end
            r_lane_valid <= w_complete ? '0 : (r_lane_valid | w_strb);
            if (w_complete) r_push_cnt <= r_push_cnt + CNT_ONE;
            if (w_pop)      r_wr_cnt   <= r_wr_cnt + CNT_ONE;
            if (w_drop)     r_drop_cnt <= r_drop_cnt + CNT_ONE;
            if (w_dup || w_drop) r_err <= 1'b1;
        end
    end

    assign wr_en   = (r_state == ST_RUN) && !w_fifo_empty;
    assign wr_addr = r_base + addr_w'(r_wr_cnt);
    assign wr_data = wr_en ? w_fifo_head : '0;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;
    assign o_state = r_state;

endmodule

// File: tb/tb_ap_writeback.sv
module tb_ap_writeback;
  import ap_writeback_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [7:0]  lane_mask = '0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_en = '0;
  logic        wr_ready = 1'b1;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy, done, err;
  ap_state_e   dbg_state;

  ap_writeback dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .lane_mask(lane_mask), .in(in_data),
    .in_en(in_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
    .o_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Layer states: 0 idle, 1 run, 2 done. exp_q holds words waiting to be
  // written, in order.
  int          m_state = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  m_lane[8];
  logic [7:0]  m_valid = '0, m_mask = '0, m_strb;
  logic [15:0] m_base = '0, m_num = '0, m_push = '0, m_wr = '0;
  logic        m_err = 1'b0, m_pop, m_wr_en;
  logic [63:0] m_word;

  // Observation log of transfers and done pulses, for literal checks.
  logic [15:0] obs_addr[$];
  logic [63:0] obs_data[$];
  int          obs_cyc[$];
  int          last_done_cyc = -1;
  int          done_cnt = 0;

  always @(negedge clk) begin
    // compare DUT against model predictions for this cycle
    m_wr_en = (m_state == 1) && (exp_q.size() > 0);
    chk("wr_en", {63'd0, wr_en}, {63'd0, m_wr_en});
    chk("busy",  {63'd0, busy},  {63'd0, (m_state != 0)});
    chk("done",  {63'd0, done},  {63'd0, (m_state == 2)});
    chk("err",   {63'd0, err},   {63'd0, m_err});
    if (m_wr_en) begin
      chk("wr_addr", {48'd0, wr_addr}, {48'd0, m_base + m_wr});
      chk("wr_data", wr_data, exp_q[0]);
    end
    if (wr_en && wr_ready) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    // advance model with the inputs applied during this cycle
    if (!reset) begin
      m_state = 0; exp_q.delete(); m_valid = '0; m_push = '0; m_wr = '0;
      m_err = 1'b0; m_base = '0; m_num = '0; m_mask = '0;
    end else begin
      case (m_state)
        0: if (start) begin
          m_base = base_addr; m_num = num_words; m_mask = lane_mask;
          m_push = '0; m_wr = '0; m_err = 1'b0; m_valid = '0;
          m_state = (num_words == 0) ? 2 : 1;
        end
        1: begin
          m_pop  = (exp_q.size() > 0) && wr_ready;
          m_strb = (m_push != m_num) ? (in_en & m_mask) : 8'h00;
          if (m_pop) begin
            void'(exp_q.pop_front());
            m_wr = m_wr + 16'd1;
          end
          if ((m_strb & m_valid) != 0) m_err = 1'b1;
          for (int b = 0; b < 8; b++)
            if (m_strb[b]) m_lane[b] = in_data[b*8 +: 8];
          m_valid = m_valid | m_strb;
          if (m_strb != 0 && (m_valid & m_mask) == m_mask) begin
            m_word = '0;
            for (int b = 0; b < 8; b++)
              if (m_mask[b]) m_word[b*8 +: 8] = m_lane[b];
            m_valid = '0;
            m_push = m_push + 16'd1;
            if (exp_q.size() < DEPTH) exp_q.push_back(m_word);
            else m_err = 1'b1;
          end
          if (m_push == m_num && exp_q.size() == 0) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n, input logic [7:0] m);
    start = 1'b1; base_addr = b; num_words = n; lane_mask = m;
    tick(1);
    start = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] en, input logic [63:0] d);
    in_en = en; in_data = d;
    tick(1);
    in_en = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (busy) begin
      n_errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
    tick(1);
  endtask

  task automatic check_write(input string name, input int idx, input logic [15:0] a, input logic [63:0] d);
    n_checks++;
    if (idx >= obs_addr.size()) begin
      n_errors++;
      $display("FAIL %s: got %0d writes, expected write #%0d", name, obs_addr.size(), idx);
    end else begin
      n_checks--;
      chk({name, "_addr"}, {48'd0, obs_addr[idx]}, {48'd0, a});
      chk({name, "_data"}, obs_data[idx], d);
    end
  endtask

  // ---------------- directed tests ----------------
  int b0, s, t, r, dc;

  initial begin
    // reset state
    tick(3);
    @(negedge clk);
    chk("rst_wr_en",   {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {48'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_busy",    {63'd0, busy}, 64'd0);
    chk("rst_done",    {63'd0, done}, 64'd0);
    chk("rst_err",     {63'd0, err}, 64'd0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // aligned lanes
    b0 = obs_addr.size();
    wr_ready = 1'b1;
    do_start(16'h0100, 16'd3, 8'hFF);
    chk("start_busy", {63'd0, busy}, 64'd1);
    strobe(8'hFF, 64'h0102030405060708);
    strobe(8'hFF, 64'h1112131415161718);
    strobe(8'hFF, 64'h2122232425262728);
    wait_idle("aligned_idle", 40);
    check_write("aligned0", b0,     16'h0100, 64'h0102030405060708);
    check_write("aligned1", b0 + 1, 16'h0101, 64'h1112131415161718);
    check_write("aligned2", b0 + 2, 16'h0102, 64'h2122232425262728);
    chk("aligned_done_cyc", 64'(last_done_cyc), 64'(obs_cyc[obs_cyc.size()-1] + 1));
    chk("aligned_err", {63'd0, err}, 64'd0);

    // skewed lanes, with an ignored start in the middle
    b0 = obs_addr.size();
    do_start(16'h0200, 16'd1, 8'hFF);
    s = cyc;
    strobe(8'hF0, 64'hA0A1A2A3_EEEEEEEE);
    start = 1'b1; base_addr = 16'hDEAD; num_words = 16'd9;
    tick(1);
    start = 1'b0;
    strobe(8'h0F, 64'hEEEEEEEE_B4B5B6B7);
    wait_idle("skew_idle", 40);
    check_write("skew", b0, 16'h0200, 64'hA0A1A2A3_B4B5B6B7);
    chk("skew_cyc", 64'(obs_cyc[b0]), 64'(s + 3));
    chk("skew_err", {63'd0, err}, 64'd0);

    // partial mask: cores 0-3 only
    b0 = obs_addr.size();
    do_start(16'h0300, 16'd2, 8'hF0);
    s = cyc;
    strobe(8'hF0, 64'hAABBCCDD_11223344);
    strobe(8'hF0, 64'h55667788_99AABBCC);
    wait_idle("partial_idle", 40);
    check_write("partial0", b0,     16'h0300, 64'hAABBCCDD_00000000);
    check_write("partial1", b0 + 1, 16'h0301, 64'h55667788_00000000);
    chk("partial_cyc0", 64'(obs_cyc[b0]), 64'(s + 1));
    chk("partial_cyc1", 64'(obs_cyc[b0 + 1]), 64'(s + 2));

    // back-pressure: 6 words complete into a 4-deep FIFO
    b0 = obs_addr.size();
    dc = done_cnt;
    wr_ready = 1'b0;
    do_start(16'h0400, 16'd6, 8'hFF);
    for (int i = 0; i < 6; i++) strobe(8'hFF, {8{8'(8'h30 + i)}});
    tick(3);
    wr_ready = 1'b1;
    wait_idle("bp_idle", 60);
    chk("bp_count", 64'(obs_addr.size() - b0), 64'd4);
    for (int i = 0; i < 4; i++)
      check_write("bp", b0 + i, 16'h0400 + 16'(i), {8{8'(8'h30 + i)}});
    chk("bp_err", {63'd0, err}, 64'd1);
    chk("bp_done", 64'(done_cnt - dc), 64'd1);

    // duplicate strobe on core 2 (bit 5, in[47:40])
    b0 = obs_addr.size();
    do_start(16'h0500, 16'd1, 8'hFF);
    chk("dup_err_cleared", {63'd0, err}, 64'd0);
    strobe(8'h20, 64'h0000_1100_0000_0000);
    strobe(8'h20, 64'h0000_2200_0000_0000);
    strobe(8'hDF, 64'hA1A2_00A4_A5A6_A7A8);
    wait_idle("dup_idle", 40);
    check_write("dup", b0, 16'h0500, 64'hA1A2_22A4_A5A6_A7A8);
    chk("dup_err", {63'd0, err}, 64'd1);

    // num_words = 0
    b0 = obs_addr.size();
    t = cyc;
    do_start(16'h0600, 16'd0, 8'hFF);
    wait_idle("zero_idle", 10);
    chk("zero_done_cyc", 64'(last_done_cyc), 64'(t + 1));
    chk("zero_writes", 64'(obs_addr.size() - b0), 64'd0);

    // reset mid-layer, then a clean run
    wr_ready = 1'b0;
    do_start(16'h0700, 16'd4, 8'hFF);
    strobe(8'hFF, 64'h1111111111111111);
    strobe(8'hFF, 64'h2222222222222222);
    strobe(8'h20, 64'h0000330000000000);
    strobe(8'h20, 64'h0000440000000000);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en",   {63'd0, wr_en}, 64'd0);
    chk("mid_rst_wr_addr", {48'd0, wr_addr}, 64'd0);
    chk("mid_rst_wr_data", wr_data, 64'd0);
    chk("mid_rst_busy",    {63'd0, busy}, 64'd0);
    chk("mid_rst_done",    {63'd0, done}, 64'd0);
    chk("mid_rst_err",     {63'd0, err}, 64'd0);
    tick(1);
    wr_ready = 1'b1;
    b0 = obs_addr.size();
    do_start(16'h0800, 16'd1, 8'hFF);
    strobe(8'hFF, 64'hC0FFEE00_12345678);
    wait_idle("post_rst_idle", 40);
    check_write("post_rst", b0, 16'h0800, 64'hC0FFEE00_12345678);

    // address wrap
    b0 = obs_addr.size();
    do_start(16'hFFFF, 16'd2, 8'hFF);
    strobe(8'hFF, 64'h0F0E0D0C0B0A0908);
    strobe(8'hFF, 64'h8090A0B0C0D0E0F0);
    wait_idle("wrap_idle", 40);
    check_write("wrap0", b0,     16'hFFFF, 64'h0F0E0D0C0B0A0908);
    check_write("wrap1", b0 + 1, 16'h0000, 64'h8090A0B0C0D0E0F0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ap_writeback.md
# ap_writeback

Output-side collector for the arithmetic part. It receives the per-core 8-bit results and per-core valid strobes that the core array emits, and aligns the lanes of one output pixel into a single packed word. It buffers these words in a small FIFO and streams them to the output feature-map memory as addressed writes, with back-pressure. It sits between the core array outputs and the output SRAM write port, and is controlled by the layer sequencer through `start`, `done` and `err`.

## Interface
- `outport`, 8: bits per core result.
- `N_core`, 8: number of cores / lanes.
- `addr_w`, 16: memory address width.
- `cnt_w`, 16: word-count width.
- `fifo_depth`, 4: packed-word FIFO entries (power of two, ≥2).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches `base_addr`, `num_words`, `lane_mask`. Only accepted in IDLE.
- `base_addr` in `addr_w`: first write address.
- `num_words` in `cnt_w`: words to collect and write.
- `lane_mask` in `N_core`: bit for core i is `lane_mask[N_core-1-i]`; lanes with a 0 bit are not waited for and are written as 0.
- `in` in `outport*N_core`: core i result at bits `[outport*N_core-i*outport-1 -: outport]`, so core 0 is in the MSBs.
- `in_en` in `N_core`: core i strobe at bit `N_core-1-i`.
- `wr_en` out 1: write request.
- `wr_addr` out `addr_w`: write address.
- `wr_data` out `outport*N_core`: packed word, same lane order as `in`.
- `wr_ready` in 1: memory accepts; a transfer occurs when `wr_en && wr_ready`.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse after the last write.
- `err` out 1: sticky error flag; cleared by reset or by an accepted `start`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`. If `num_words==0`, go IDLE→DONE instead.
  - RUN→DONE when the write counter reaches `num_words`.
  - DONE→IDLE unconditionally, one cycle later. `done` is high only in DONE.
- Lane capture (RUN only; `in_en` is ignored elsewhere):
  - Each lane has a data register and a `lane_valid` bit. When `in_en` is high on a masked lane, the data is stored and `lane_valid` is set.
  - If a lane strobes while its `lane_valid` is already set, the new data overwrites the old and `err` is set.
- Word completion: `((lane_valid | in_en) & lane_mask) == lane_mask`, evaluated with at least one masked strobe present this cycle.
  - On that edge the merged word (this cycle's strobes take priority) is pushed to the FIFO, all `lane_valid` bits clear, and the push counter increments.
  - If the FIFO is full at completion, the word is dropped, `err` is set, and the push counter still increments so the layer terminates.
  - Once the push counter equals `num_words`, further strobes are ignored.
- Write side: the FIFO is show-ahead. `wr_en = RUN && !fifo_empty`, and `wr_data` is the FIFO head.
  - `wr_addr = base_addr + write_count`, wrapping modulo 2^`addr_w`.
  - On a transfer, pop the FIFO and increment `write_count`.
  - If the FIFO is full, a push and a pop may occur in the same cycle; the pop frees the slot, so no overflow is flagged.
- Dropped words are never written. The FSM moves RUN→DONE when `write_count + dropped == num_words`. A single counter of push-accepted words covers this: the FIFO is empty and the push counter equals `num_words`.
- Reset (any state, including mid-layer) clears:
  - the FSM to IDLE;
  - the FIFO pointers;
  - all counters;
  - `lane_valid`;
  - `err`.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`, `err=0`.
- `start` at cycle t → `busy=1` from t+1.
- Completing strobe at cycle t with the FIFO empty → `wr_en=1` at t+1. `wr_en` stays high until a cycle with `wr_ready=1`.
- Sustained throughput: one word per cycle while `wr_ready=1`.
- Last transfer at cycle t → state DONE and `done=1` at t+1 → IDLE and `busy=0` at t+2.
- `start` arriving in RUN or DONE is ignored and leaves `err` unaffected.

## Structure
- Shared package: FSM state encoding (IDLE/RUN/DONE) and default widths (`outport`, `N_core`). These are shared with the core array and the input-feeder block.
- Sub-module `ap_wb_fifo`: synchronous show-ahead FIFO, parameterized by width and depth, with `push`/`pop`/`full`/`empty` and synchronous active-low `reset`. Lane alignment, counters and the FSM stay in the top module.

## Test plan
- Aligned lanes: `lane_mask=8'hFF`, `num_words=3`, `base_addr=16'h0100`. Strobe all lanes with `in` = 64'h0102030405060708, then ...1112..., then ...2122..., with `wr_ready=1`. Expect writes to 0x100/0x101/0x102 with those data, `done` 2 cycles after the first strobe follows the third write, and `err=0`.
- Skewed lanes: cores 0–3 strobe at cycle t, cores 4–7 at t+2. Expect a single write at t+3 with the merged word.
- Partial mask: `lane_mask=8'hF0`, strobes on cores 0–3 only. Expect words with the low 32 bits equal to 0, written one cycle after each strobe.
- Back-pressure: `wr_ready=0` for 10 cycles while 6 words complete, `fifo_depth=4`. Expect 4 words written in order after `wr_ready` rises, `err=1`, `done` asserted, and no hang.
- Duplicate strobe: core 2 strobes twice (values 8'h11 then 8'h22) before the other lanes. Expect the written word to carry 8'h22 in lane 2 and `err=1`.
- Boundaries: `num_words=0` → `done` at t+1 with no writes. Assert `reset=0` mid-layer → all outputs 0 the next cycle, and a following `start` runs cleanly. A run with `base_addr=16'hFFFF`, `num_words=2` writes 0xFFFF then 0x0000.
